// File: rtl/waarde_naar_pwm_ramp.sv
// Motor PWM generator: maps a speed level to a compare value that ramps in bounded steps once per period.
// Optional emergency stop input enabled by defining WNP_NOODSTOP_EN.
module waarde_naar_pwm_ramp #(
  parameter int unsigned PERIOD  = 24000,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LEVEL_W = 3,
  parameter int unsigned STEP    = 240
) (
  input  logic               Klok,
  input  logic               Reset,
  input  logic               Enable,
  input  logic [LEVEL_W-1:0] Invoer,
`ifdef WNP_NOODSTOP_EN
  input  logic               Noodstop,
`endif
  output logic               PWM,
  output logic [CNT_W-1:0]   Compare,
  output logic               Bezig,
  output logic               PeriodeStart
);

  localparam logic [CNT_W-1:0] LVL0   = CNT_W'(PERIOD * 5 / 100);
  localparam logic [CNT_W-1:0] LVL1   = CNT_W'(PERIOD * 20 / 100);
  localparam logic [CNT_W-1:0] LVL2   = CNT_W'(PERIOD * 40 / 100);
  localparam logic [CNT_W-1:0] LVL3   = CNT_W'(PERIOD * 60 / 100);
  localparam logic [CNT_W-1:0] LVL4   = CNT_W'(PERIOD * 80 / 100);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   STEP_X = (CNT_W + 1)'(STEP);

  // Elaboration-time parameter sanity
  if (64'(PERIOD) > (64'(1) << CNT_W)) begin : g_bad_period
    $error("PERIOD exceeds 2**CNT_W");
  end
  if (PERIOD < 2) begin : g_small_period
    $error("PERIOD must be at least 2");
  end
  if (STEP < 1) begin : g_bad_step
    $error("STEP must be at least 1");
  end

  logic [CNT_W-1:0] teller_q, teller_d;
  logic [CNT_W-1:0] doel_q, doel_d;
  logic [CNT_W-1:0] compare_q, compare_d;
  logic             pwm_q, pwm_d;
  logic             bezig_q, bezig_d;
  logic             pstart_q, pstart_d;

  logic [CNT_W-1:0] level_val;
  logic [CNT_W-1:0] ramp_val;
  logic [CNT_W:0]   cmp_x, doel_x, diff_x;
  logic             nood;

`ifdef WNP_NOODSTOP_EN
  assign nood = Noodstop;
`else
  assign nood = 1'b0;
`endif

  // Level table lookup, levels above 3 clamp to the 80 % entry
  always_comb begin
    level_val = LVL4;
    case (32'(Invoer))
      32'd0:   level_val = LVL0;
      32'd1:   level_val = LVL1;
      32'd2:   level_val = LVL2;
      32'd3:   level_val = LVL3;
      default: level_val = LVL4;
    endcase
  end

  // One bounded ramp step toward Doel, in CNT_W+1 bits so neither direction can wrap
  always_comb begin
    cmp_x    = {1'b0, compare_q};
    doel_x   = {1'b0, doel_q};
    diff_x   = '0;
    ramp_val = doel_q;
    if (doel_x >= cmp_x) begin
      diff_x = doel_x - cmp_x;
      if (diff_x > STEP_X) begin
        ramp_val = CNT_W'(cmp_x + STEP_X);
      end
    end else begin
      diff_x = cmp_x - doel_x;
      if (diff_x > STEP_X) begin
        ramp_val = CNT_W'(cmp_x - STEP_X);
      end
    end
  end

  always_comb begin
    teller_d  = (teller_q == LAST) ? '0 : teller_q + CNT_W'(1);
    doel_d    = Enable ? level_val : '0;
    compare_d = (teller_q == LAST) ? ramp_val : compare_q;
    pwm_d     = (teller_q < compare_q);
    pstart_d  = (teller_q == '0);
    bezig_d   = (compare_q != doel_q);
    if (nood) begin
      doel_d    = '0;
      compare_d = '0;
      pwm_d     = 1'b0;
      bezig_d   = 1'b0;
    end
  end

  always_ff @(posedge Klok) begin
    if (Reset) begin
      teller_q  <= '0;
      doel_q    <= '0;
      compare_q <= '0;
      pwm_q     <= 1'b0;
      bezig_q   <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      teller_q  <= teller_d;
      doel_q    <= doel_d;
      compare_q <= compare_d;
      pwm_q     <= pwm_d;
      bezig_q   <= bezig_d;
      pstart_q  <= pstart_d;
    end
  end

  assign PWM          = pwm_q;
  assign Compare      = compare_q;
  assign Bezig        = bezig_q;
  assign PeriodeStart = pstart_q;

endmodule

// File: tb/tb_waarde_naar_pwm_ramp.sv
// Bench for waarde_naar_pwm_ramp at PERIOD=100, STEP=10; compares against an arithmetic model every cycle.
module tb_waarde_naar_pwm_ramp;

  localparam int P = 100;
  localparam int S = 10;

  logic        Klok = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [2:0]  Invoer;
  logic        Noodstop;
  logic        PWM;
  logic [15:0] Compare;
  logic        Bezig;
  logic        PeriodeStart;

  int errors = 0;
  int checks = 0;

  waarde_naar_pwm_ramp #(.PERIOD(P), .CNT_W(16), .LEVEL_W(3), .STEP(S)) dut (
    .Klok(Klok),
    .Reset(Reset),
    .Enable(Enable),
    .Invoer(Invoer),
`ifdef WNP_NOODSTOP_EN
    .Noodstop(Noodstop),
`endif
    .PWM(PWM),
    .Compare(Compare),
    .Bezig(Bezig),
    .PeriodeStart(PeriodeStart)
  );

  always #5 Klok = ~Klok;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tbl(input int lvl);
    case (lvl)
      0: return P * 5 / 100;
      1: return P * 20 / 100;
      2: return P * 40 / 100;
      3: return P * 60 / 100;
      default: return P * 80 / 100;
    endcase
  endfunction

  // Reference model: position in the period, target, duty, and the registered outputs
  int m_t = 0, m_d = 0, m_c = 0;
  int m_pwm = 0, m_ps = 0, m_bz = 0;
  bit m_valid = 1'b0;

  always @(posedge Klok) begin
    if (Reset) begin
      m_t = 0; m_d = 0; m_c = 0; m_pwm = 0; m_ps = 0; m_bz = 0;
      m_valid = 1'b1;
    end else if (Noodstop) begin
      m_pwm = 0; m_bz = 0; m_ps = (m_t == 0) ? 1 : 0;
      m_c = 0; m_d = 0;
      m_t = (m_t + 1) % P;
    end else begin
      m_pwm = (m_t < m_c) ? 1 : 0;
      m_ps  = (m_t == 0) ? 1 : 0;
      m_bz  = (m_c != m_d) ? 1 : 0;
      if (m_t == P - 1) begin
        if (m_d > m_c) m_c = (m_c + S < m_d) ? m_c + S : m_d;
        else           m_c = (m_c - S > m_d) ? m_c - S : m_d;
      end
      m_d = Enable ? tbl(int'(Invoer)) : 0;
      m_t = (m_t + 1) % P;
    end
  end

  always @(negedge Klok) begin
    if (m_valid) begin
      check("pwm", int'(PWM), m_pwm);
      check("compare", int'(Compare), m_c);
      check("bezig", int'(Bezig), m_bz);
      check("periodestart", int'(PeriodeStart), m_ps);
    end
  end

  // Advance to the negedge just after the next period-end edge
  task automatic wait_pe();
    int n = 0;
    do begin
      @(negedge Klok);
      n++;
    end while (m_t != 0 && n <= P + 1);
    if (m_t != 0) begin
      errors++; checks++;
      $display("FAIL wait_pe: timeout after %0d cycles", n);
    end
  endtask

  task automatic wait_teller(input int t);
    int n = 0;
    do begin
      @(negedge Klok);
      n++;
    end while (m_t != t && n <= P + 1);
    if (m_t != t) begin
      errors++; checks++;
      $display("FAIL wait_teller: timeout waiting for %0d", t);
    end
  endtask

  task automatic count_period(output int hi, output int ps);
    hi = 0; ps = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge Klok);
      hi += int'(PWM);
      ps += int'(PeriodeStart);
    end
  endtask

  initial begin
    int hi, ps;
    int up_seq[8];
    int dn_seq[6];
    int off_seq[8];
    up_seq  = '{15, 25, 35, 45, 55, 65, 75, 80};
    dn_seq  = '{70, 60, 50, 40, 30, 20};
    off_seq = '{70, 60, 50, 40, 30, 20, 10, 0};

    Reset = 1'b1; Enable = 1'b1; Invoer = 3'd0; Noodstop = 1'b0;
    repeat (2) @(negedge Klok);
    check("reset_pwm", int'(PWM), 0);
    check("reset_compare", int'(Compare), 0);
    check("reset_bezig", int'(Bezig), 0);
    check("reset_pstart", int'(PeriodeStart), 0);
    Reset = 1'b0;

    // Level 0 from reset
    wait_pe();
    check("s1_compare", int'(Compare), 5);
    count_period(hi, ps);
    check("s1_pwm_high", hi, 5);
    check("s1_pstart_count", ps, 1);

    // Ramp up to 80
    Invoer = 3'd4;
    for (int i = 0; i < 8; i++) begin
      wait_pe();
      check("s2_step", int'(Compare), up_seq[i]);
    end
    @(negedge Klok);
    check("s2_bezig_done", int'(Bezig), 0);

    // Clamp, then ramp down landing on 20
    Invoer = 3'd7;
    repeat (3) @(negedge Klok);
    check("s3_clamp_compare", int'(Compare), 80);
    check("s3_clamp_bezig", int'(Bezig), 0);
    Invoer = 3'd1;
    for (int i = 0; i < 6; i++) begin
      wait_pe();
      check("s3_step", int'(Compare), dn_seq[i]);
    end
    wait_pe();
    check("s3_hold", int'(Compare), 20);

    // Soft stop from 80
    Invoer = 3'd4;
    repeat (6) wait_pe();
    check("s4_top", int'(Compare), 80);
    Enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_pe();
      check("s4_step", int'(Compare), off_seq[i]);
    end
    count_period(hi, ps);
    check("s4_pwm_high", hi, 0);
    check("s4_bezig", int'(Bezig), 0);

    // Reset mid-ramp at Compare=45, Teller=37
    Enable = 1'b1; Invoer = 3'd0;
    wait_pe();
    check("s5_start", int'(Compare), 5);
    Invoer = 3'd3;
    repeat (4) wait_pe();
    check("s5_at45", int'(Compare), 45);
    wait_teller(37);
    Reset = 1'b1;
    @(negedge Klok);
    check("s5_pwm", int'(PWM), 0);
    check("s5_compare", int'(Compare), 0);
    check("s5_bezig", int'(Bezig), 0);
    check("s5_pstart", int'(PeriodeStart), 0);
    Reset = 1'b0;
    wait_pe();
    check("s5_restart", int'(Compare), 10);

`ifdef WNP_NOODSTOP_EN
    // Emergency stop at Compare=60
    repeat (5) wait_pe();
    check("s6_at60", int'(Compare), 60);
    wait_teller(50);
    Noodstop = 1'b1;
    @(negedge Klok);
    check("s6_pwm", int'(PWM), 0);
    check("s6_compare", int'(Compare), 0);
    check("s6_bezig", int'(Bezig), 0);
    repeat (5) @(negedge Klok);
    Noodstop = 1'b0;
    wait_pe();
    check("s6_resume", int'(Compare), 10);
`endif

    repeat (3) @(negedge Klok);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
